// File: rtl/traf_pkg.sv
// Shared definitions for the traffic-light controller and its request conditioner.
package traf_pkg;
   localparam logic [1:0] LIGHT_RED    = 2'b00;
   localparam logic [1:0] LIGHT_YELLOW = 2'b01;
   localparam logic [1:0] LIGHT_GREEN  = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      SERV = 2'd2
   } req_state_t;
endpackage

// File: rtl/traf_debounce.sv
// Two-flop synchroniser plus counting debouncer with registered level and rising-edge outputs.
module traf_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise
);
   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic [1:0]    sync;
   logic          deb;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '0;
         deb   <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         // any sample agreeing with the current level restarts the run
         if (sync[1] == deb) begin
            cnt <= '0;
         end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            deb <= sync[1];
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         level <= deb;
         rise  <= deb & ~level;
      end
   end
endmodule

// File: rtl/traf_req_cond.sv
// Request conditioner: latches debounced car/pedestrian requests until the side lamp goes green.
module traf_req_cond
   import traf_pkg::*;
#(
   parameter int DEB_CYCLES = 4,
   parameter int MAX_WAIT   = 20,
   parameter int WAIT_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              car_raw,
   input  logic              ped_raw,
   input  logic [1:0]        highway,
   input  logic [1:0]        side,
   output logic              side_req,
   output logic              ped_pend,
   output logic              urgent,
   output logic [WAIT_W-1:0] wait_cnt
);
   localparam logic [WAIT_W-1:0] MAX_WAIT_W = WAIT_W'(MAX_WAIT);

   req_state_t        state;
   logic              car_ev, ped_ev, car_rise_unused;
   logic              car_pend, ped_next;
   logic              side_green;
   logic [WAIT_W-1:0] wait_inc;

   traf_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_car (
      .clk(clk), .rst_n(rst_n), .raw(car_raw), .level(car_ev), .rise(car_rise_unused)
   );
   traf_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ped (
      .clk(clk), .rst_n(rst_n), .raw(ped_raw), .level(), .rise(ped_ev)
   );

   // both lamps green is illegal; it still means the side road is being served
   assign side_green = (side == LIGHT_GREEN) || ((highway == LIGHT_GREEN) && (side == LIGHT_GREEN));
   assign wait_inc   = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
   assign side_req   = car_pend | ped_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         car_pend <= 1'b0;
         ped_pend <= 1'b0;
         ped_next <= 1'b0;
         urgent   <= 1'b0;
         wait_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (side_green) begin
                  state <= SERV;
               end else if (car_ev || ped_ev) begin
                  state    <= PEND;
                  car_pend <= car_ev;
                  ped_pend <= ped_ev;
                  wait_cnt <= '0;
                  urgent   <= 1'b0;
               end
            end
            PEND: begin
               if (side_green) begin
                  state    <= SERV;
                  car_pend <= 1'b0;
                  ped_pend <= 1'b0;
                  wait_cnt <= '0;
                  urgent   <= 1'b0;
               end else begin
                  car_pend <= car_pend | car_ev;
                  ped_pend <= ped_pend | ped_ev;
                  wait_cnt <= wait_inc;
                  urgent   <= (wait_inc >= MAX_WAIT_W);
               end
            end
            SERV: begin
               if (!side_green) begin
                  // a press landing on the exit cycle still misses this phase
                  if (ped_next || ped_ev) begin
                     state    <= PEND;
                     ped_pend <= 1'b1;
                     wait_cnt <= '0;
                     urgent   <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
                  ped_next <= 1'b0;
               end else begin
                  ped_next <= ped_next | ped_ev;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_traf_req_cond.sv
// Directed bench for traf_req_cond: debounce latency, service handshake, wait/urgent, bounce rejection.
module tb_traf_req_cond;
   import traf_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n, car_raw, ped_raw;
   logic [1:0] highway, side;
   logic       side_req, ped_pend, urgent;
   logic [7:0] wait_cnt;
   logic       side_req5, ped_pend5, urgent5;
   logic [4:0] wait_cnt5;
   int         n_cmp = 0, n_err = 0, rise_cnt = 0;

   always #5 clk = ~clk;

   traf_req_cond #(.DEB_CYCLES(4), .MAX_WAIT(20), .WAIT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .car_raw(car_raw), .ped_raw(ped_raw),
      .highway(highway), .side(side), .side_req(side_req), .ped_pend(ped_pend),
      .urgent(urgent), .wait_cnt(wait_cnt)
   );
   traf_req_cond #(.DEB_CYCLES(4), .MAX_WAIT(20), .WAIT_W(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .car_raw(car_raw), .ped_raw(ped_raw),
      .highway(highway), .side(side), .side_req(side_req5), .ped_pend(ped_pend5),
      .urgent(urgent5), .wait_cnt(wait_cnt5)
   );

   always @(negedge clk) if (dut.u_ped.rise === 1'b1) rise_cnt <= rise_cnt + 1;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; car_raw = 1'b0; ped_raw = 1'b0;
      highway = LIGHT_GREEN; side = LIGHT_RED;
      tick(2);
      chk("rst_side_req", 32'(side_req), 0);
      chk("rst_ped_pend", 32'(ped_pend), 0);
      chk("rst_urgent",   32'(urgent), 0);
      chk("rst_wait_cnt", 32'(wait_cnt), 0);
      chk("rst_state",    32'(dut.state), 32'(IDLE));
      rst_n = 1'b1;
      tick(2);

      // short glitch of 3 samples is rejected
      car_raw = 1'b1; tick(3); car_raw = 1'b0; tick(10);
      chk("glitch_no_req", 32'(side_req), 0);

      // held car: request appears 7 cycles after first sample
      car_raw = 1'b1;
      tick(7); chk("car_lat_m1", 32'(side_req), 0);
      tick(1); chk("car_lat",    32'(side_req), 1);
      chk("car_wait0", 32'(wait_cnt), 0);
      tick(1); chk("car_wait1", 32'(wait_cnt), 1);

      // service with illegal both-green combination
      side = LIGHT_GREEN;
      tick(1);
      chk("serv_req_clr", 32'(side_req), 0);
      chk("serv_state",   32'(dut.state), 32'(SERV));
      tick(3); chk("serv_car_ignored", 32'(side_req), 0);
      side = LIGHT_YELLOW;
      tick(1);
      chk("exit_idle",     32'(dut.state), 32'(IDLE));
      chk("exit_req_zero", 32'(side_req), 0);
      tick(1); chk("car_rerequest", 32'(side_req), 1);
      car_raw = 1'b0; side = LIGHT_RED; tick(10);
      side = LIGHT_GREEN; tick(1); side = LIGHT_RED; tick(1);
      chk("clear_idle", 32'(side_req), 0);

      // ped press during green is deferred to the next phase
      side = LIGHT_GREEN; tick(1);
      ped_raw = 1'b1; tick(10); ped_raw = 1'b0;
      chk("ped_deferred", 32'(ped_pend), 0);
      side = LIGHT_YELLOW; tick(1);
      chk("ped_next_pend", 32'(ped_pend), 1);
      chk("ped_next_wait", 32'(wait_cnt), 0);
      chk("ped_next_state", 32'(dut.state), 32'(PEND));

      // wait counter, urgent threshold and saturation
      side = LIGHT_RED;
      tick(19);
      chk("wait19",    32'(wait_cnt), 19);
      chk("urgent_19", 32'(urgent), 0);
      tick(1);
      chk("wait20",    32'(wait_cnt), 20);
      chk("urgent_20", 32'(urgent), 1);
      chk("urgent5_20", 32'(urgent5), 1);
      tick(11);
      chk("wait5_31", 32'(wait_cnt5), 31);
      tick(5);
      chk("wait5_sat", 32'(wait_cnt5), 31);
      chk("wait_36",   32'(wait_cnt), 36);
      side = LIGHT_GREEN; tick(1);
      chk("serv_urgent_clr", 32'(urgent), 0);
      chk("serv_wait_clr",   32'(wait_cnt), 0);
      side = LIGHT_RED; tick(1);
      chk("back_idle", 32'(dut.state), 32'(IDLE));

      // bouncy button then steady press
      tick(8);
      rise_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         ped_raw = 1'b1; tick(2); ped_raw = 1'b0; tick(2);
      end
      chk("bounce_no_ev", 32'(ped_pend), 0);
      ped_raw = 1'b1; tick(12);
      chk("bounce_one_ev", 32'(rise_cnt), 1);
      chk("bounce_pend",   32'(ped_pend), 1);

      // reset while pending
      rst_n = 1'b0; tick(1);
      chk("midrst_req",    32'(side_req), 0);
      chk("midrst_ped",    32'(ped_pend), 0);
      chk("midrst_wait",   32'(wait_cnt), 0);
      chk("midrst_state",  32'(dut.state), 32'(IDLE));
      rst_n = 1'b1; tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
